// File: rtl/flag_event_log.sv
// Event logger: captures a stamp per flag_in pulse into a first-word-fall-through FIFO.
// Define FLAG_EVENT_LOG_TIMESTAMP_EN to store the timer value instead of the sequence number.
module flag_event_log #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flag_in,
  input  logic                     clr,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [DW-1:0]            evt_data,
  output logic [$clog2(DEPTH):0]   evt_level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] seq_q, seq_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [DW-1:0] capture;
  logic          full, push, pop, drop;

`ifdef FLAG_EVENT_LOG_TIMESTAMP_EN
  logic [DW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = clr ? '0 : timer_q + DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign capture = timer_q;
`else
  assign capture = seq_q;
`endif

  assign full = (level_q == FullLvl);
  assign pop  = ~clr & evt_ready & (level_q != '0);
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push = ~clr & flag_in & (~full | pop);
  assign drop = ~clr & flag_in & full & ~pop;

  always_comb begin
    seq_d      = seq_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clr) begin
      seq_d      = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (flag_in) seq_d = seq_q + DW'(1);
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop) rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      seq_q      <= seq_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is not reset; the level counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= capture;
  end

  assign evt_valid = (level_q != '0);
  assign evt_data  = evt_valid ? mem_q[rptr_q] : '0;
  assign evt_level = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_flag_event_log.sv
// Directed bench for flag_event_log in the default (sequence-number) build, DEPTH=4, DW=16.
module tb_flag_event_log;

  logic        clk;
  logic        rst_n;
  logic        flag_in;
  logic        clr;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_data;
  logic [2:0]  evt_level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks;
  int errors;

  flag_event_log #(
    .DEPTH(4),
    .DW   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag_in  (flag_in),
    .clr      (clr),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data (evt_data),
    .evt_level(evt_level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    flag_in   = 1'b0;
    clr       = 1'b0;
    evt_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_data", 32'(evt_data), 32'd0);
    chk("rst_level", 32'(evt_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // First event right after reset release, seq 0, visible next cycle
    flag_in = 1'b1;
    cyc();
    flag_in = 1'b0;
    chk("first_valid", 32'(evt_valid), 32'd1);
    chk("first_data", 32'(evt_data), 32'd0);
    chk("first_level", 32'(evt_level), 32'd1);
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
    chk("pop_valid", 32'(evt_valid), 32'd0);
    chk("pop_level", 32'(evt_level), 32'd0);
    chk("pop_data", 32'(evt_data), 32'd0);

    // Six back-to-back events into DEPTH=4: seq 1..4 kept, 5 and 6 dropped
    flag_in = 1'b1;
    repeat (6) cyc();
    flag_in = 1'b0;
    chk("ovf_level", 32'(evt_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(evt_data), 32'(i + 1));
      cyc();
    end
    evt_ready = 1'b0;
    chk("drain_level", 32'(evt_level), 32'd0);
    chk("drain_valid", 32'(evt_valid), 32'd0);
    chk("sticky_ovf", 32'(overflow), 32'd1);

    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // Fill with seq 0..3, then push seq 4 while popping: no drop
    flag_in = 1'b1;
    repeat (4) cyc();
    chk("full_level", 32'(evt_level), 32'd4);
    chk("full_head", 32'(evt_data), 32'd0);
    evt_ready = 1'b1;
    cyc();
    flag_in = 1'b0;
    chk("pp_level", 32'(evt_level), 32'd4);
    chk("pp_drop", 32'(drop_cnt), 32'd0);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("pp_drain", 32'(evt_data), 32'(i + 1));
      cyc();
    end
    evt_ready = 1'b0;
    chk("pp_empty", 32'(evt_level), 32'd0);

    // Three entries (seq 5..7), then clr with flag_in and evt_ready high
    flag_in = 1'b1;
    repeat (3) cyc();
    flag_in = 1'b0;
    chk("three_level", 32'(evt_level), 32'd3);
    chk("three_head", 32'(evt_data), 32'd5);
    clr       = 1'b1;
    flag_in   = 1'b1;
    evt_ready = 1'b1;
    cyc();
    clr       = 1'b0;
    flag_in   = 1'b0;
    evt_ready = 1'b0;
    chk("clr2_level", 32'(evt_level), 32'd0);
    chk("clr2_valid", 32'(evt_valid), 32'd0);
    chk("clr2_ovf", 32'(overflow), 32'd0);
    chk("clr2_drop", 32'(drop_cnt), 32'd0);
    flag_in = 1'b1;
    cyc();
    flag_in = 1'b0;
    chk("clr2_seq0", 32'(evt_data), 32'd0);
    chk("clr2_lvl1", 32'(evt_level), 32'd1);
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;

    // 300 events with no consumer: seq 1..4 kept, drop count saturates
    flag_in = 1'b1;
    repeat (300) cyc();
    flag_in = 1'b0;
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    chk("sat_level", 32'(evt_level), 32'd4);
    chk("sat_head", 32'(evt_data), 32'd1);

    evt_ready = 1'b1;
    repeat (2) cyc();
    evt_ready = 1'b0;
    chk("mid_level", 32'(evt_level), 32'd2);
    chk("mid_head", 32'(evt_data), 32'd3);

    // Asynchronous reset mid-cycle, observed before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(evt_valid), 32'd0);
    chk("arst_data", 32'(evt_data), 32'd0);
    chk("arst_level", 32'(evt_level), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_drop", 32'(drop_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;

    // Event into empty FIFO with evt_ready high: push only, seq restarts at 0
    flag_in   = 1'b1;
    evt_ready = 1'b1;
    cyc();
    flag_in = 1'b0;
    chk("post_level", 32'(evt_level), 32'd1);
    chk("post_seq0", 32'(evt_data), 32'd0);
    cyc();
    evt_ready = 1'b0;
    chk("post_empty", 32'(evt_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_event_log.md
FLAG_EVENT_LOG -- requirements
Module: flag_event_log

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; power of two, 2..16.
REQ-002 Parameter: DW, 16, width of event data and of the free-running timer.
REQ-003 Port: clk  input  1  clock; all state on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: flag_in  input  1  event pulse from the window detector; every high cycle is one event.
REQ-006 Port: clr  input  1  synchronous clear of FIFO, timer, sequence counter and status.
REQ-007 Port: evt_valid  output  1  head entry available.
REQ-008 Port: evt_ready  input  1  consumer accepts head when evt_valid=1.
REQ-009 Port: evt_data  output  DW  head entry; 0 when evt_valid=0.
REQ-010 Port: evt_level  output  log2(DEPTH)+1  current number of stored entries.
REQ-011 Port: overflow  output  1  sticky; an event was dropped.
REQ-012 Port: drop_cnt  output  8  saturating count of dropped events.

Function
REQ-013 timer: DW-bit counter, +1 every cycle, wraps from all-ones to 0.
REQ-014 seq: DW-bit counter, +1 on every flag_in cycle, dropped events included, wraps; consumer detects gaps from it.
REQ-015 Capture value for an event at cycle N = timer (or seq, see Configuration) value present during cycle N, before that edge's increment.
REQ-016 FIFO first-word-fall-through; evt_valid = (evt_level != 0); evt_data = oldest entry.
REQ-017 Push on flag_in=1 when not full, or when full and a pop occurs the same cycle.
REQ-018 Pop when evt_valid=1 and evt_ready=1; evt_ready while empty has no effect.
REQ-019 Simultaneous push and pop: evt_level unchanged; when empty, no pop, push only.
REQ-020 Latency: flag_in at cycle N into empty FIFO gives evt_valid=1 from cycle N+1.
REQ-021 flag_in high on consecutive cycles: each cycle is a separate event.
REQ-022 Drop: flag_in=1, full, no pop -> entry discarded, overflow set, drop_cnt +1 saturating at 255.
REQ-023 Read/write pointers log2(DEPTH) bits, wrap naturally; full = (evt_level == DEPTH).
REQ-024 clr=1: evt_level, pointers, timer, seq, overflow, drop_cnt to 0 at that edge; a flag_in or pop in the same cycle is ignored.
REQ-025 evt_data and evt_valid stable while evt_valid=1 and evt_ready=0.

Reset
REQ-026 rst_n low: evt_valid=0, evt_data=0, evt_level=0, overflow=0, drop_cnt=0, timer=0, seq=0, pointers=0, immediately and asynchronously.
REQ-027 Reset mid-operation discards all stored entries; storage array contents need not be reset.
REQ-028 First event after rst_n deasserts is captured normally on the first rising edge.

Configuration
REQ-029 Macro FLAG_EVENT_LOG_TIMESTAMP_EN defined: stored entry = timer value (REQ-015); seq still drives drop accounting.
REQ-030 Macro not defined: timer absent; stored entry = seq value of the event; all other behaviour identical.

Verification
REQ-031 TIMESTAMP_EN, reset release then flag_in at timer=0x0005, evt_ready=1 -> evt_valid=1 next cycle, evt_data=0x0005, evt_level=1, then 0.
REQ-032 DEPTH=4, evt_ready=0, 6 flag_in pulses -> evt_level=4, overflow=1, drop_cnt=2; drain -> first 4 events in order.
REQ-033 Seq mode, full FIFO, flag_in with evt_valid&evt_ready same cycle -> evt_level stays 4, no drop, new tail = seq 4.
REQ-034 300 flag_in pulses with evt_ready=0 -> drop_cnt=255 (saturated), overflow=1.
REQ-035 FIFO holding 3 entries, clr=1 with flag_in=1 -> next cycle evt_level=0, evt_valid=0, overflow=0, drop_cnt=0, timer=0.
REQ-036 rst_n low mid-drain with 2 entries -> evt_valid=0 and evt_data=0 without a clock edge; post-reset first event gets seq 0.
